// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer. Beats accepted when empty appear one cycle later.
// InReady comes only from registered state, so a stall on OutReady takes effect one beat late. The skid register absorbs that beat.
module ex_mem_skid_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int MEM_W  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic              Flush,
   input  logic              RegWrite,
   input  logic              MemToReg,
   input  logic [MEM_W-1:0]  MemWrite,
   input  logic [MEM_W-1:0]  MemRead,
   input  logic [DATA_W-1:0] RData2,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] PCAddResult,
   input  logic [REG_W-1:0]  RdReg,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              RegWriteOut,
   output logic              MemToRegOut,
   output logic [MEM_W-1:0]  MemWriteOut,
   output logic [MEM_W-1:0]  MemReadOut,
   output logic [DATA_W-1:0] RData2Out,
   output logic [DATA_W-1:0] ALUResultOut,
   output logic [DATA_W-1:0] PCAddResultOut,
   output logic [REG_W-1:0]  RdRegOut,
   output logic [CNT_W-1:0]  StallCount
);

   localparam int BEAT_W   = 2 + 2 * MEM_W + 3 * DATA_W + REG_W;
   localparam int OFS_PC   = REG_W;
   localparam int OFS_ALU  = OFS_PC + DATA_W;
   localparam int OFS_RD2  = OFS_ALU + DATA_W;
   localparam int OFS_MRD  = OFS_RD2 + DATA_W;
   localparam int OFS_MWR  = OFS_MRD + MEM_W;
   localparam int OFS_M2R  = OFS_MWR + MEM_W;
   localparam int OFS_RW   = OFS_M2R + 1;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]        r_state;
   logic [BEAT_W-1:0] r_main;
   logic [BEAT_W-1:0] r_skid;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [1:0]        w_state_nxt;
   logic [BEAT_W-1:0] w_main_nxt;
   logic [BEAT_W-1:0] w_skid_nxt;
   logic [CNT_W-1:0]  w_stall_cnt_nxt;
   logic [BEAT_W-1:0] w_in_beat;
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_accept;
   logic              w_fire;
   logic              w_stall;

   assign w_in_beat = {RegWrite, MemToReg, MemWrite, MemRead,
                       RData2, ALUResult, PCAddResult, RdReg};

   assign w_in_ready  = (r_state != ST_TWO);
   assign w_out_valid = (r_state == ST_ONE) || (r_state == ST_TWO);
   assign w_accept    = InValid & w_in_ready;
   assign w_fire      = w_out_valid & OutReady;
   assign w_stall     = w_out_valid & ~OutReady & ~Flush;

   // Main is zeroed whenever the stage empties, so control outputs read as a bubble without gating.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (Flush) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = '0;
         w_skid_nxt  = '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = w_in_beat;
               end
            end
            ST_ONE: begin
               if (w_accept && w_fire) begin
                  w_main_nxt = w_in_beat;
               end else if (w_accept) begin
                  w_state_nxt = ST_TWO;
                  w_skid_nxt  = w_in_beat;
               end else if (w_fire) begin
                  w_state_nxt = ST_EMPTY;
                  w_main_nxt  = '0;
               end
            end
            ST_TWO: begin
               if (w_fire) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = r_skid;
                  w_skid_nxt  = '0;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_main_nxt  = '0;
               w_skid_nxt  = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_stall_cnt_nxt = r_stall_cnt;
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
         w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state     <= ST_EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_main      <= w_main_nxt;
         r_skid      <= w_skid_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
      end
   end

   assign InReady        = w_in_ready;
   assign OutValid       = w_out_valid;
   assign RegWriteOut    = r_main[OFS_RW];
   assign MemToRegOut    = r_main[OFS_M2R];
   assign MemWriteOut    = r_main[OFS_MWR +: MEM_W];
   assign MemReadOut     = r_main[OFS_MRD +: MEM_W];
   assign RData2Out      = r_main[OFS_RD2 +: DATA_W];
   assign ALUResultOut   = r_main[OFS_ALU +: DATA_W];
   assign PCAddResultOut = r_main[OFS_PC +: DATA_W];
   assign RdRegOut       = r_main[REG_W-1:0];
   assign StallCount     = r_stall_cnt;

endmodule

// File: doc/ex_mem_skid_stage.md
EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of RData2, ALUResult and PCAddResult payload fields.
REQ-002 Parameter REG_W, default 5: width of the destination register index.
REQ-003 Parameter MEM_W, default 2: width of the MemWrite/MemRead control fields.
REQ-004 Parameter CNT_W, default 16: width of the stall counter.
REQ-005 Clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-006 Reset  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-007 InValid  input  1  upstream (execute) beat valid.
REQ-008 InReady  output  1  stage can accept a beat this cycle.
REQ-009 Flush  input  1  discard all held beats.
REQ-010 RegWrite, MemToReg  input  1 each  control bits of incoming beat.
REQ-011 MemWrite, MemRead  input  MEM_W each  memory control of incoming beat.
REQ-012 RData2, ALUResult, PCAddResult  input  DATA_W each  payload of incoming beat.
REQ-013 RdReg  input  REG_W  destination register of incoming beat.
REQ-014 OutValid  output  1  held beat presented downstream.
REQ-015 OutReady  input  1  downstream (data memory) accepts presented beat.
REQ-016 RegWriteOut, MemToRegOut, MemWriteOut, MemReadOut, RData2Out, ALUResultOut, PCAddResultOut, RdRegOut  output  widths as inputs  presented beat.
REQ-017 StallCount  output  CNT_W  cycles spent back-pressured.

Function
REQ-018 Accept = InValid & InReady; Fire = OutValid & OutReady; Flush overrides both.
REQ-019 Storage SHALL be two beat registers, Main (drives outputs) and Skid; state EMPTY, ONE (Main full), TWO (Main and Skid full).
REQ-020 InReady SHALL be 1 in EMPTY and ONE, 0 in TWO, decoded from registered state only (no combinational path from OutReady).
REQ-021 OutValid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-022 EMPTY: Accept -> ONE, Main <= input; else hold.
REQ-023 ONE: Accept & Fire -> ONE, Main <= input; Accept & !Fire -> TWO, Skid <= input; !Accept & Fire -> EMPTY; neither -> hold.
REQ-024 TWO: Fire -> ONE, Main <= Skid; else hold; no input accepted.
REQ-025 Latency: a beat accepted in EMPTY SHALL appear on outputs the next cycle; beat order SHALL be preserved; no beat dropped or duplicated absent Flush.
REQ-026 Flush=1 at a rising edge SHALL force next state EMPTY and discard Main, Skid and any same-cycle input beat.
REQ-027 Whenever OutValid=0, RegWriteOut, MemToRegOut, MemWriteOut and MemReadOut SHALL be 0 (bubble); data outputs are don't-care but SHALL be registered.
REQ-028 Control outputs SHALL be driven from registers, not gated combinationally by OutValid.
REQ-029 StallCount SHALL increment by 1 each cycle OutValid=1, OutReady=0 and Flush=0, saturate at 2^CNT_W-1, and not be cleared by Flush.
REQ-030 While held (no Fire), all output fields SHALL remain stable.

Reset
REQ-031 Reset=0 at a rising edge SHALL set state EMPTY, OutValid 0, InReady 1 on the following cycle, all Out fields 0, StallCount 0.
REQ-032 Reset SHALL take priority over Flush, Accept and Fire; beats in flight SHALL be discarded.

Verification
REQ-033 Pass-through: OutReady=1, InValid=1 for beats ALUResult=0x10,0x20,0x30 -> same values on ALUResultOut on consecutive cycles, one cycle after each accept, InReady stays 1.
REQ-034 Back-pressure: OutReady=0, push beats RdReg=3 then RdReg=7 -> state TWO, InReady=0, RdRegOut=3; raise OutReady -> RdRegOut=3 then 7, no loss.
REQ-035 Flush in TWO with InValid=1 and RegWrite=1 -> next cycle OutValid=0, RegWriteOut=0, MemWriteOut=0, InReady=1; flushed beats never appear.
REQ-036 Stall counter: CNT_W=4, OutValid=1, OutReady=0 for 20 cycles -> StallCount reaches 15 and holds 15.
REQ-037 Reset mid-operation: state TWO, StallCount=5, Reset=0 for one edge -> OutValid=0, all Out fields 0, StallCount=0, InReady=1.
REQ-038 Simultaneous accept and fire in ONE for 8 cycles with MemWrite=2'b01 beats -> state remains ONE, one beat out per cycle, StallCount unchanged.
